// File: rtl/dsp48e1_slice_pkg.sv
// dsp48e1_slice_pkg: widths, OPMODE/ALUMODE encodings and ALU helpers for the DSP48E1 slice model.
package dsp48e1_slice_pkg;
  localparam int A_W = 30;
  localparam int B_W = 18;
  localparam int P_W = 48;
  localparam int AD_W = 25;
  localparam int M_W = 43;
  localparam int CTRL_W = 16;
  localparam logic [1:0] X_M = 2'b01;
  localparam logic [1:0] X_P = 2'b10;
  localparam logic [1:0] X_AB = 2'b11;
  localparam logic [1:0] Y_M = 2'b01;
  localparam logic [1:0] Y_ONES = 2'b10;
  localparam logic [1:0] Y_C = 2'b11;
  localparam logic [2:0] Z_PCIN = 3'b001;
  localparam logic [2:0] Z_P = 3'b010;
  localparam logic [2:0] Z_C = 3'b011;
  localparam logic [2:0] Z_PCIN17 = 3'b101;
  localparam logic [2:0] Z_P17 = 3'b110;
  localparam logic [3:0] ALU_NZADD = 4'b0001;
  localparam logic [3:0] ALU_NSUM = 4'b0010;
  localparam logic [3:0] ALU_ZSUB = 4'b0011;
  function automatic logic [P_W-1:0] asr17(input logic [P_W-1:0] v);
    return {{17{v[P_W-1]}}, v[P_W-1:17]};
  endfunction
  // s is X+Y+CIN; unlisted modes fall back to plain addition
  function automatic logic [P_W-1:0] alu(input logic [3:0] mode, input logic [P_W-1:0] z, input logic [P_W-1:0] s);
    return mode == ALU_ZSUB ? z - s : mode == ALU_NZADD ? s + ~z : mode == ALU_NSUM ? ~(z + s) : z + s;
  endfunction
endpackage

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: optional pipeline stage with clock enable and async active-low clear; EN=0 makes it a wire.
module dsp_pipe_reg #(
  parameter int WIDTH = 1,
  parameter bit EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d;
  assign q_d = ce_i ? d_i : q_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_q <= '0;
    else q_q <= q_d;
  assign q_o = EN ? q_q : d_i;
endmodule

// File: rtl/dsp48e1_slice.sv
// dsp48e1_slice: DSP48E1-style MAC slice (pre-adder, 25x18 multiplier, 48-bit ALU, cascade).
// Define DSP48_PREADD_EN to build the D port, pre-adder and D/AD registers.
module dsp48e1_slice
  import dsp48e1_slice_pkg::*;
#(
  parameter int AREG = 1,
  parameter int BREG = 1,
  parameter int CREG = 1,
  parameter int DREG = 1,
  parameter int ADREG = 1,
  parameter int MREG = 1,
  parameter int PREG = 1,
  parameter int OPMODEREG = 1
) (
  input  logic        c_i,
  input  logic        rst_ni,
  input  logic [29:0] a_i,
  input  logic [17:0] b_i,
  input  logic [47:0] c_data_i,
  input  logic [24:0] d_i,
  input  logic [47:0] pcin_i,
  input  logic [6:0]  opmode_i,
  input  logic [3:0]  alumode_i,
  input  logic [4:0]  inmode_i,
  input  logic        carryin_i,
  input  logic        ce_a1_i,
  input  logic        ce_a2_i,
  input  logic        ce_b_i,
  input  logic        ce_c_i,
  input  logic        ce_d_i,
  input  logic        ce_ad_i,
  input  logic        ce_m_i,
  input  logic        ce_p_i,
  input  logic        ce_ctrl_i,
  output logic [47:0] p_o,
  output logic [47:0] pcout_o
);
  logic [A_W-1:0] a1, a2;
  logic [B_W-1:0] b;
  logic [P_W-1:0] c_r, p, p_d, x, y, z;
  logic [AD_W-1:0] a_pre, ad;
  logic [M_W-1:0] m_d, m;
  logic [6:0] opmode;
  logic [3:0] alumode;
  logic [4:0] inmode;
  // With AREG=1 the single A register is A2, so A1 collapses to a wire
  dsp_pipe_reg #(.WIDTH(A_W), .EN(AREG == 2)) u_a1 (.clk_i(c_i), .rst_ni, .ce_i(ce_a1_i), .d_i(a_i), .q_o(a1));
  dsp_pipe_reg #(.WIDTH(A_W), .EN(AREG >= 1)) u_a2 (.clk_i(c_i), .rst_ni, .ce_i(ce_a2_i), .d_i(a1), .q_o(a2));
  dsp_pipe_reg #(.WIDTH(B_W), .EN(BREG != 0)) u_b (.clk_i(c_i), .rst_ni, .ce_i(ce_b_i), .d_i(b_i), .q_o(b));
  dsp_pipe_reg #(.WIDTH(P_W), .EN(CREG != 0)) u_c (.clk_i(c_i), .rst_ni, .ce_i(ce_c_i), .d_i(c_data_i), .q_o(c_r));
  dsp_pipe_reg #(.WIDTH(CTRL_W), .EN(OPMODEREG != 0)) u_ctrl (
    .clk_i(c_i), .rst_ni, .ce_i(ce_ctrl_i),
    .d_i({opmode_i, alumode_i, inmode_i}), .q_o({opmode, alumode, inmode})
  );
  assign a_pre = inmode[0] ? a1[AD_W-1:0] : a2[AD_W-1:0];
`ifdef DSP48_PREADD_EN
  logic [AD_W-1:0] d_r, a_opr, d_term, ad_d;
  dsp_pipe_reg #(.WIDTH(AD_W), .EN(DREG != 0)) u_d (.clk_i(c_i), .rst_ni, .ce_i(ce_d_i), .d_i(d_i), .q_o(d_r));
  dsp_pipe_reg #(.WIDTH(AD_W), .EN(ADREG != 0)) u_ad (.clk_i(c_i), .rst_ni, .ce_i(ce_ad_i), .d_i(ad_d), .q_o(ad));
  assign a_opr = inmode[1] ? '0 : a_pre;
  assign d_term = inmode[2] ? d_r : '0;
  assign ad_d = inmode[3] ? d_term - a_opr : d_term + a_opr;
`else
  logic preadd_unused;
  assign ad = a_pre;
  assign preadd_unused = ^{d_i, inmode[4:1], ce_d_i, ce_ad_i, DREG != 0, ADREG != 0};
`endif
  // Both operands widened to the product width so the low 43 bits are the signed product
  assign m_d = {{(M_W-AD_W){ad[AD_W-1]}}, ad} * {{(M_W-B_W){b[B_W-1]}}, b};
  dsp_pipe_reg #(.WIDTH(M_W), .EN(MREG != 0)) u_m (.clk_i(c_i), .rst_ni, .ce_i(ce_m_i), .d_i(m_d), .q_o(m));
  always_comb begin
    x = (opmode[1:0] == X_M && opmode[3:2] == Y_M) ? {{(P_W-M_W){m[M_W-1]}}, m}
      : opmode[1:0] == X_P ? p : opmode[1:0] == X_AB ? {a2, b} : '0;
    y = opmode[3:2] == Y_ONES ? '1 : opmode[3:2] == Y_C ? c_r : '0;
    z = opmode[6:4] == Z_PCIN ? pcin_i : opmode[6:4] == Z_P ? p : opmode[6:4] == Z_C ? c_r
      : opmode[6:4] == Z_PCIN17 ? asr17(pcin_i) : opmode[6:4] == Z_P17 ? asr17(p) : '0;
    p_d = alu(alumode, z, x + y + P_W'(carryin_i));
  end
  dsp_pipe_reg #(.WIDTH(P_W), .EN(PREG != 0)) u_p (.clk_i(c_i), .rst_ni, .ce_i(ce_p_i), .d_i(p_d), .q_o(p));
  assign p_o = p;
  assign pcout_o = p;
endmodule

// File: tb/tb_dsp48e1_slice.sv
// tb_dsp48e1_slice: directed checks of the DSP48E1 slice (two cascaded slices plus an AREG=2 slice).
module tb_dsp48e1_slice;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, carryin, ce_b;
  logic [29:0] a, a1;
  logic [17:0] b, b1;
  logic [24:0] d, d1;
  logic [47:0] c_data, pcin, p0, pc0, p1, pc1, p2, pc2;
  logic [6:0] opmode;
  logic [3:0] alumode;
  logic [4:0] inmode;
  int n_assert = 0;
  int n_fail = 0;
`ifdef DSP48_PREADD_EN
  localparam int LA = 4;
  localparam longint E_M = 56, E_SIGN = 20, E_DMA = 14, E_A0 = 35, E_CAS = 176;
`else
  localparam int LA = 3;
  localparam longint E_M = 21, E_SIGN = 8, E_DMA = 21, E_A0 = 21, E_CAS = 131;
`endif
  dsp48e1_slice u0 (
    .c_i(clk), .rst_ni(rst_n), .a_i(a), .b_i(b), .c_data_i(c_data), .d_i(d), .pcin_i(pcin),
    .opmode_i(opmode), .alumode_i(alumode), .inmode_i(inmode), .carryin_i(carryin),
    .ce_a1_i(1'b1), .ce_a2_i(1'b1), .ce_b_i(ce_b), .ce_c_i(1'b1), .ce_d_i(1'b1), .ce_ad_i(1'b1),
    .ce_m_i(1'b1), .ce_p_i(1'b1), .ce_ctrl_i(1'b1), .p_o(p0), .pcout_o(pc0)
  );
  dsp48e1_slice u1 (
    .c_i(clk), .rst_ni(rst_n), .a_i(a1), .b_i(b1), .c_data_i(48'd0), .d_i(d1), .pcin_i(pc0),
    .opmode_i(7'b0010101), .alumode_i(4'b0000), .inmode_i(5'b00100), .carryin_i(1'b0),
    .ce_a1_i(1'b1), .ce_a2_i(1'b1), .ce_b_i(1'b1), .ce_c_i(1'b1), .ce_d_i(1'b1), .ce_ad_i(1'b1),
    .ce_m_i(1'b1), .ce_p_i(1'b1), .ce_ctrl_i(1'b1), .p_o(p1), .pcout_o(pc1)
  );
  dsp48e1_slice #(.AREG(2)) u2 (
    .c_i(clk), .rst_ni(rst_n), .a_i(a), .b_i(b), .c_data_i(c_data), .d_i(d), .pcin_i(pcin),
    .opmode_i(opmode), .alumode_i(alumode), .inmode_i(inmode), .carryin_i(carryin),
    .ce_a1_i(1'b1), .ce_a2_i(1'b1), .ce_b_i(ce_b), .ce_c_i(1'b1), .ce_d_i(1'b1), .ce_ad_i(1'b1),
    .ce_m_i(1'b1), .ce_p_i(1'b1), .ce_ctrl_i(1'b1), .p_o(p2), .pcout_o(pc2)
  );
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask
  initial begin
    rst_n = 1'b0; a = '0; b = '0; c_data = '0; pcin = '0; d = '0;
    opmode = '0; alumode = '0; inmode = '0; carryin = 1'b0; ce_b = 1'b1;
    a1 = 30'd1; b1 = 18'd10; d1 = 25'd1;
    tick(2);
    check("rst_p", p0, 48'd0);
    check("rst_pcout", pc0, 48'd0);
    rst_n = 1'b1; a = 30'd3; d = 25'd5; b = 18'd7; c_data = 48'd100;
    inmode = 5'b00100; opmode = 7'b0110101;
    tick(LA - 1);
    check("base_early", p0, 48'd100);
    tick(1);
    check("base", p0, 100 + E_M);
    tick(2);
    check("base_hold", p0, 100 + E_M);
    check("base_pcout", pc0, 100 + E_M);
    check("cascade_p", p1, E_CAS);
    check("cascade_pcout", pc1, E_CAS);
    a = -30'sd2; d = -25'sd3; b = -18'sd4; c_data = '0;
    tick(LA);
    check("signs", p0, E_SIGN);
    a = 30'd3; d = 25'd5; b = 18'd7; inmode = 5'b01100;
    tick(LA);
    check("d_minus_a", p0, E_DMA);
    inmode = 5'b00110;
    tick(LA);
    check("a_forced_zero", p0, E_A0);
    inmode = 5'b00100; c_data = 48'd100; alumode = 4'b0011;
    tick(LA);
    check("alu_zsub", p0, 100 - E_M);
    alumode = 4'b0001;
    tick(LA);
    check("alu_nzadd", p0, -100 + E_M - 1);
    alumode = 4'b0010;
    tick(LA);
    check("alu_nsum", p0, -(100 + E_M) - 1);
    alumode = 4'b0000; carryin = 1'b1;
    tick(LA);
    check("carryin", p0, 100 + E_M + 1);
    carryin = 1'b0; opmode = 7'b0000011; a = 30'd1; b = 18'd2;
    tick(LA);
    check("x_ab", p0, 48'd262146);
    opmode = 7'b0111000; c_data = 48'd5;
    tick(LA);
    check("y_ones", p0, 48'd4);
    opmode = 7'b1010000; pcin = -48'sd1048576;
    tick(LA);
    check("pcin_asr17", p0, -48'sd8);
    pcin = '0; opmode = 7'b0110101; c_data = '0; a = 30'd3; d = 25'd5; b = 18'd7; ce_b = 1'b1;
    tick(LA);
    check("ce_load", p0, E_M);
    ce_b = 1'b0; b = 18'd9;
    tick(LA + 2);
    check("ce_hold", p0, E_M);
    opmode = 7'b0100101;
    tick(2);
    check("acc_2", p0, 2 * E_M);
    tick(1);
    check("acc_3", p0, 3 * E_M);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_p", p0, 48'd0);
    check("async_rst_pcout", pc0, 48'd0);
    a = '0; b = '0; d = '0; c_data = '0; opmode = '0; inmode = '0; alumode = '0; ce_b = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    check("post_rst", p0, 48'd0);
    opmode = 7'b0000101; b = 18'd7;
    tick(LA + 2);
    check("areg2_zero", p2, 48'd0);
    a = 30'd3;
    tick(LA);
    check("areg1_step", p0, 48'd21);
    check("areg2_early", p2, 48'd0);
    tick(1);
    check("areg2_step", p2, 48'd21);
    check("areg2_pcout", pc2, 48'd21);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
